// File: rtl/cyber_player.sv
// cyber_player: computer opponent that emits single-cycle press pulses at LFSR-randomised decision ticks
module cyber_player #(
  parameter int TICK_DIV = 65536,
  parameter int LFSR_W   = 10,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              enable,
  input  logic [LFSR_W-1:0] difficulty,
  output logic              press,
  output logic              tick,
  output logic [LFSR_W-1:0] lfsr_state,
  output logic [CNT_W-1:0]  press_count
);
  localparam int PW = $clog2(TICK_DIV);
  logic [PW-1:0]     pre_q, pre_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              press_q, press_d, tick_q, tick_c;
  // Next-state: prescaler wrap, XNOR LFSR step and press decision all use the pre-advance state
  always_comb begin
    tick_c  = pre_q == PW'(TICK_DIV - 1);
    pre_d   = tick_c ? '0 : pre_q + PW'(1);
    lfsr_d  = tick_c ? {lfsr_q[LFSR_W-2:0], ~(lfsr_q[9] ^ lfsr_q[6])} : lfsr_q;
    press_d = tick_c & enable & (difficulty > lfsr_q);
    cnt_d   = (press_q && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  // State registers with synchronous reset taking priority over any pending press
  always_ff @(posedge clk) begin
    if (Reset) begin
      pre_q   <= '0;
      lfsr_q  <= '0;
      cnt_q   <= '0;
      press_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      tick_q  <= tick_c;
    end
  end
  assign press       = press_q;
  assign tick        = tick_q;
  assign lfsr_state  = lfsr_q;
  assign press_count = cnt_q;
endmodule
